// File: rtl/score_pkg.sv
// Shared types and constants for the score controller: FSM states, the 7-segment
// glyph table and an MSD-first BCD magnitude compare.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        UPDATE  = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int MAX_DIGITS = 6;
    localparam int BCD_W      = 4 * MAX_DIGITS;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Game-logic side of the score controller: control levels in, score/display out.
interface score_ctrl_if #(parameter int NUM_DIGITS = 3);
    logic                      start;
    logic                      detect_score;
    logic                      game_over;
    logic                      show_high;
    logic [4*NUM_DIGITS-1:0]   score_bcd;
    logic [4*NUM_DIGITS-1:0]   high_bcd;
    logic [7*NUM_DIGITS-1:0]   HEX;
    logic                      playing;
    logic                      new_high;
    logic                      saturated;

    modport master (
        output start, detect_score, game_over, show_high,
        input  score_bcd, high_bcd, HEX, playing, new_high, saturated
    );

    modport slave (
        input  start, detect_score, game_over, show_high,
        output score_bcd, high_bcd, HEX, playing, new_high, saturated
    );
endinterface

// File: rtl/score_ctrl_seg7.sv
// Combinational BCD digit to active-low 7-segment glyph; non-BCD codes go dark.
module bcd_seg7
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/score_ctrl.sv
// Game score controller: strobe edge detect, game FSM, saturating BCD score,
// session high score and registered 7-segment display drive.
module score_ctrl
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    score_ctrl_if.slave  bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int HW = 7 * NUM_DIGITS;

    state_t            state, state_nxt;
    logic              det_q, pulse, enter_play, saturated, new_high, carry, above;
    logic [W-1:0]      score, high, score_inc, disp;
    logic [HW-1:0]     hex_q, hex_nxt, hex_rst, seg_raw;
    logic [NUM_DIGITS-1:0] zero_above;

    assign pulse      = bus.detect_score & ~det_q;
    assign enter_play = bus.start && ((state == IDLE) || (state == OVER));

    always_comb begin
        saturated = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (score[4*i +: 4] != 4'd9) saturated = 1'b0;
    end

    // Ripple carry: a digit advances only while every lower digit wraps from 9.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (score[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)     state_nxt = PLAYING;
            PLAYING: if (bus.game_over) state_nxt = UPDATE;
            UPDATE:                     state_nxt = OVER;
            OVER:    if (bus.start)     state_nxt = PLAYING;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            det_q    <= 1'b1;
            score    <= '0;
            high     <= '0;
            new_high <= 1'b0;
        end else begin
            det_q <= bus.detect_score;
            if (enter_play) begin
                score    <= '0;
                new_high <= 1'b0;
            end else if ((state == PLAYING) && pulse && !saturated) begin
                score <= score_inc;
            end
            if (state == UPDATE) begin
                if (bcd_gt(BCD_W'(score), BCD_W'(high))) begin
                    high     <= score;
                    new_high <= 1'b1;
                end else begin
                    new_high <= 1'b0;
                end
            end
        end
    end

    assign disp = bus.show_high ? high : score;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_seg7 u_seg (
            .digit (disp[4*g +: 4]),
            .seg   (seg_raw[7*g +: 7])
        );
        assign hex_rst[7*g +: 7] = (BLANK_LZ && (g > 0)) ? SEG_BLANK : SEG_0;
    end

    always_comb begin
        zero_above = '0;
        above      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above         = above && (disp[4*i +: 4] == 4'd0);
            zero_above[i] = above;
        end
    end

    always_comb begin
        hex_nxt = seg_raw;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (BLANK_LZ && zero_above[i]) hex_nxt[7*i +: 7] = SEG_BLANK;
    end

    always_ff @(posedge clock) begin
        if (reset) hex_q <= hex_rst;
        else       hex_q <= hex_nxt;
    end

    assign bus.score_bcd = score;
    assign bus.high_bcd  = high;
    assign bus.HEX       = hex_q;
    assign bus.playing   = (state == PLAYING);
    assign bus.new_high  = new_high;
    assign bus.saturated = saturated;
endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: two instances (leading-zero blanking on/off)
// share stimulus; expected snapshots are queued and checked by a monitor.
module tb_score_ctrl;
    logic clock = 1'b0;
    logic reset;
    logic start, detect_score, game_over, show_high;

    always #5 clock = ~clock;

    score_ctrl_if #(.NUM_DIGITS(3)) ifa ();
    score_ctrl_if #(.NUM_DIGITS(3)) ifb ();

    assign ifa.start = start;         assign ifb.start = start;
    assign ifa.detect_score = detect_score; assign ifb.detect_score = detect_score;
    assign ifa.game_over = game_over; assign ifb.game_over = game_over;
    assign ifa.show_high = show_high; assign ifb.show_high = show_high;

    score_ctrl #(.NUM_DIGITS(3), .BLANK_LZ(1'b1)) dut    (.clock(clock), .reset(reset), .bus(ifa));
    score_ctrl #(.NUM_DIGITS(3), .BLANK_LZ(1'b0)) dut_nz (.clock(clock), .reset(reset), .bus(ifb));

    localparam logic [6:0] H0 = 7'h40, H1 = 7'h79, H2 = 7'h24, H3 = 7'h30, H5 = 7'h12;
    localparam logic [6:0] H7 = 7'h78, H8 = 7'h00, H9 = 7'h10, HB = 7'h7F;

    typedef struct {
        string       name;
        logic [11:0] score;
        logic [11:0] high;
        logic [20:0] hex;
        logic [20:0] hex_nz;
        logic        pl;
        logic        nh;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [11:0] s, input logic [11:0] h,
                             input logic [20:0] hx, input logic [20:0] hxn,
                             input logic pl, input logic nh, input logic sat);
        exp_t e;
        e.name = name; e.score = s; e.high = h; e.hex = hx; e.hex_nz = hxn;
        e.pl = pl; e.nh = nh; e.sat = sat;
        sb.push_back(e);
    endtask

    task automatic pulse();
        detect_score = 1'b1;
        repeat (3) tick();
        detect_score = 1'b0;
        tick();
    endtask

    task automatic end_game();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        tick();
    endtask

    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check(input exp_t e);
        bit bad;
        bad = 1'b0;
        tests++;
        if (ifa.score_bcd !== e.score) begin
            $display("FAIL %s score_bcd: got %h want %h", e.name, ifa.score_bcd, e.score); bad = 1'b1;
        end
        if (ifa.high_bcd !== e.high) begin
            $display("FAIL %s high_bcd: got %h want %h", e.name, ifa.high_bcd, e.high); bad = 1'b1;
        end
        if (ifa.HEX !== e.hex) begin
            $display("FAIL %s HEX: got %h want %h", e.name, ifa.HEX, e.hex); bad = 1'b1;
        end
        if (ifb.HEX !== e.hex_nz) begin
            $display("FAIL %s HEX(no blank): got %h want %h", e.name, ifb.HEX, e.hex_nz); bad = 1'b1;
        end
        if (ifa.playing !== e.pl) begin
            $display("FAIL %s playing: got %b want %b", e.name, ifa.playing, e.pl); bad = 1'b1;
        end
        if (ifa.new_high !== e.nh) begin
            $display("FAIL %s new_high: got %b want %b", e.name, ifa.new_high, e.nh); bad = 1'b1;
        end
        if (ifa.saturated !== e.sat) begin
            $display("FAIL %s saturated: got %b want %b", e.name, ifa.saturated, e.sat); bad = 1'b1;
        end
        if (bad) fails++;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (sb.size() > 0) check(sb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        reset = 1'b1; start = 1'b0; detect_score = 1'b1; game_over = 1'b0; show_high = 1'b0;
        repeat (2) tick();
        expect_st("reset", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 0, 0, 0);
        reset = 1'b0;
        repeat (2) tick();
        expect_st("release_strobe_high", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 0, 0, 0);

        game_over = 1'b1; detect_score = 1'b0;
        tick();
        game_over = 1'b0;
        tick();
        expect_st("idle_ignores_over", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 0, 0, 0);

        begin_game();
        expect_st("start", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 1, 0, 0);
        repeat (11) pulse();
        expect_st("score_11", 12'h011, 12'h000, {HB,H1,H1}, {H0,H1,H1}, 1, 0, 0);
        detect_score = 1'b1;
        tick();
        expect_st("lat_score", 12'h012, 12'h000, {HB,H1,H1}, {H0,H1,H1}, 1, 0, 0);
        tick();
        expect_st("lat_hex", 12'h012, 12'h000, {HB,H1,H2}, {H0,H1,H2}, 1, 0, 0);
        tick();
        detect_score = 1'b0;
        tick();

        repeat (87) pulse();
        expect_st("score_99", 12'h099, 12'h000, {HB,H9,H9}, {H0,H9,H9}, 1, 0, 0);
        pulse();
        expect_st("carry_100", 12'h100, 12'h000, {H1,H0,H0}, {H1,H0,H0}, 1, 0, 0);

        repeat (899) pulse();
        expect_st("score_999", 12'h999, 12'h000, {H9,H9,H9}, {H9,H9,H9}, 1, 0, 1);
        repeat (3) pulse();
        expect_st("sat_hold", 12'h999, 12'h000, {H9,H9,H9}, {H9,H9,H9}, 1, 0, 1);
        end_game();
        expect_st("sat_over", 12'h999, 12'h999, {H9,H9,H9}, {H9,H9,H9}, 0, 1, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_st("reset_clears_high", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 0, 0, 0);

        begin_game();
        repeat (5) pulse();
        end_game();
        expect_st("game1_high", 12'h005, 12'h005, {HB,HB,H5}, {H0,H0,H5}, 0, 1, 0);
        begin_game();
        expect_st("game2_entry", 12'h000, 12'h005, {HB,HB,H5}, {H0,H0,H5}, 1, 0, 0);
        repeat (3) pulse();
        end_game();
        expect_st("game2_low", 12'h003, 12'h005, {HB,HB,H3}, {H0,H0,H3}, 0, 0, 0);
        show_high = 1'b1;
        tick();
        expect_st("show_high", 12'h003, 12'h005, {HB,HB,H5}, {H0,H0,H5}, 0, 0, 0);
        show_high = 1'b0;
        tick();

        begin_game();
        repeat (7) pulse();
        detect_score = 1'b1; game_over = 1'b1;
        tick();
        game_over = 1'b0;
        expect_st("same_edge", 12'h008, 12'h005, {HB,HB,H7}, {H0,H0,H7}, 0, 0, 0);
        tick();
        expect_st("same_edge_high", 12'h008, 12'h008, {HB,HB,H8}, {H0,H0,H8}, 0, 1, 0);
        detect_score = 1'b0;
        tick();

        begin_game();
        repeat (2) pulse();
        begin_game();
        expect_st("start_ignored", 12'h002, 12'h008, {HB,HB,H2}, {H0,H0,H2}, 1, 0, 0);
        pulse();
        expect_st("still_playing", 12'h003, 12'h008, {HB,HB,H3}, {H0,H0,H3}, 1, 0, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_st("reset_mid_game", 12'h000, 12'h000, {HB,HB,H0}, {H0,H0,H0}, 0, 0, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
